// File: rtl/bcd_seg_formatter.sv
// -----------------------------------------------------------------------------
// bcd_seg_formatter
//   Sequential binary-to-BCD formatter sitting between the I2C ADC reader and
//   Seg_Display. An accepted sample is converted by double dabble, one bit per
//   clock. The result is then packed into a 32-bit digit-code word: a prefix
//   digit, blanks, and the number with its leading zeros blanked.
//
// Ports
//   sys_clk    in   1        system clock
//   sys_rst_n  in   1        synchronous reset, active low
//   din        in   DATA_W   unsigned binary sample
//   din_vld    in   1        sample valid; taken only while busy==0
//   busy       out  1        conversion in progress (SHIFT or PACK)
//   seg_val    out  32       packed digit codes, nibble 7 = leftmost digit
//   seg_vld    out  1        one-cycle pulse when seg_val has just been updated
//
// Timing: accept on edge T0, result visible after edge T0+DATA_W+1.
// -----------------------------------------------------------------------------
module bcd_seg_formatter #(
    parameter int          DATA_W = 8,
    parameter int          DIGITS = 3,
    parameter logic [3:0]  PREFIX = 4'd15,
    parameter logic [3:0]  BLANK  = 4'd10
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    output logic              busy,
    output logic [31:0]       seg_val,
    output logic              seg_vld
);

    localparam int          BCD_W   = 4 * DIGITS;
    localparam int          CNT_W   = $clog2(DATA_W + 1);
    localparam logic [31:0] RST_VAL = {PREFIX, {7{BLANK}}};

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PACK} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        seg_val_q, seg_val_d;
    logic               seg_vld_q, seg_vld_d;

    logic               load, shift_en, pack_en;
    logic [BCD_W-1:0]   bcd_adj;
    logic [31:0]        seg_word;
    logic               lead;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (din_vld) state_d = S_SHIFT;
            // Leave on the edge that takes the count from 1 to 0.
            S_SHIFT: if (cnt_q == CNT_W'(1)) state_d = S_PACK;
            S_PACK:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs / controls ----------------
    always_comb begin
        busy     = (state_q != S_IDLE);
        load     = (state_q == S_IDLE) && din_vld;
        shift_en = (state_q == S_SHIFT);
        pack_en  = (state_q == S_PACK);
    end

    // ---------------- datapath ----------------
    // Add-3 correction on every BCD nibble >= 5 before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // Leading-zero blanking: scan from the most significant digit; the
    // units digit is always shown so a zero sample still displays "0".
    always_comb begin
        seg_word = RST_VAL;
        lead     = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (!(lead && (bcd_q[4*i +: 4] == 4'd0) && (i != 0))) begin
                seg_word[4*i +: 4] = bcd_q[4*i +: 4];
                lead = 1'b0;
            end
        end
    end

    always_comb begin
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        seg_val_d = seg_val_q;
        seg_vld_d = 1'b0;
        if (load) begin
            bin_d = din;
            bcd_d = '0;
            cnt_d = CNT_W'(DATA_W);
        end else if (shift_en) begin
            // {bcd,bin} << 1. The accumulator never overflows, so its top
            // bit is always 0; it is recycled into the vacated bin LSB
            // rather than discarded.
            {bcd_d, bin_d} = {bcd_adj[BCD_W-2:0], bin_q, bcd_adj[BCD_W-1]};
            cnt_d          = cnt_q - CNT_W'(1);
        end
        if (pack_en) begin
            seg_val_d = seg_word;
            seg_vld_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            seg_val_q <= RST_VAL;
            seg_vld_q <= 1'b0;
        end else begin
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            seg_val_q <= seg_val_d;
            seg_vld_q <= seg_vld_d;
        end
    end

    assign seg_val = seg_val_q;
    assign seg_vld = seg_vld_q;

endmodule

// File: tb/tb_bcd_seg_formatter.sv
// Bench for bcd_seg_formatter: a cycle-level acceptance model pushes the
// expected word and due cycle into a scoreboard; a negedge monitor checks
// busy, seg_vld and seg_val every cycle.
module tb_bcd_seg_formatter;

    localparam int          DATA_W  = 8;
    localparam int          DIGITS  = 3;
    localparam logic [3:0]  PREFIX  = 4'd15;
    localparam logic [3:0]  BLANK   = 4'd10;
    localparam logic [31:0] RST_VAL = {PREFIX, {7{BLANK}}};

    logic              sys_clk;
    logic              sys_rst_n;
    logic [DATA_W-1:0] din;
    logic              din_vld;
    logic              busy;
    logic [31:0]       seg_val;
    logic              seg_vld;

    bcd_seg_formatter #(
        .DATA_W(DATA_W), .DIGITS(DIGITS), .PREFIX(PREFIX), .BLANK(BLANK)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .din(din), .din_vld(din_vld),
        .busy(busy), .seg_val(seg_val), .seg_vld(seg_vld)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] val;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          mdl_cnt = 0;
    int          n_acc = 0;
    bit          started = 0;
    logic [31:0] last_val = RST_VAL;
    int          vectors = 0;
    int          miscompares = 0;

    // Expected display word from decimal digits of v.
    function automatic logic [31:0] ref_word(int unsigned v);
        logic [31:0] w;
        int          nd;
        int unsigned t;
        w = {8{BLANK}};
        w[31:28] = PREFIX;
        nd = 1;
        t = v / 10;
        while (t > 0) begin nd++; t = t / 10; end
        t = v;
        for (int i = 0; i < nd; i++) begin
            w[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Acceptance model: idle countdown of DATA_W+1 edges after each accept.
    always @(posedge sys_clk) begin
        cyc++;
        if (!sys_rst_n) begin
            mdl_cnt  = 0;
            sb.delete();
            last_val = RST_VAL;
            started  = 1;
        end else if (mdl_cnt == 0 && din_vld) begin
            sb.push_back('{val: ref_word(din), due: cyc + DATA_W + 1});
            mdl_cnt = DATA_W + 1;
            n_acc++;
        end else if (mdl_cnt > 0) begin
            mdl_cnt--;
        end
    end

    // Monitor
    always @(negedge sys_clk) begin
        if (started) begin
            if ($isunknown({busy, seg_vld, seg_val})) begin
                vectors++;
                miscompares++;
                $display("FAIL xcheck cyc=%0d got=%b/%b/%h want=no X", cyc, busy, seg_vld, seg_val);
            end
            chk("busy", 32'(busy), 32'(mdl_cnt > 0));
            if (sb.size() > 0 && sb[0].due == cyc) begin
                chk("seg_vld_pulse", 32'(seg_vld), 32'd1);
                chk("seg_val_new", seg_val, sb[0].val);
                last_val = sb[0].val;
                void'(sb.pop_front());
            end else begin
                chk("seg_vld_quiet", 32'(seg_vld), 32'd0);
                chk("seg_val_hold", seg_val, last_val);
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (mdl_cnt != 0 && t < 50) begin @(negedge sys_clk); t++; end
        if (t >= 50) begin
            vectors++; miscompares++;
            $display("FAIL wait_idle cyc=%0d got=timeout want=idle", cyc);
        end
    endtask

    task automatic send(input logic [DATA_W-1:0] v);
        wait_idle();
        din     = v;
        din_vld = 1'b1;
        @(negedge sys_clk);
        din_vld = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 50) begin @(negedge sys_clk); t++; end
        if (t >= 50) begin
            vectors++; miscompares++;
            $display("FAIL drain cyc=%0d got=%0d pending want=0", cyc, sb.size());
        end
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic wait_acc(input int target);
        int t = 0;
        while (n_acc < target && t < 50) begin @(negedge sys_clk); t++; end
        if (t >= 50) begin
            vectors++; miscompares++;
            $display("FAIL wait_acc cyc=%0d got=%0d want=%0d", cyc, n_acc, target);
        end
    endtask

    initial begin
        int a;
        din       = '0;
        din_vld   = 1'b0;
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Idle after reset
        repeat (20) @(negedge sys_clk);

        // Directed values
        send(8'd0);
        send(8'd7);
        send(8'd42);
        send(8'd100);
        send(8'd255);
        drain();

        // Sample offered while busy is dropped
        send(8'd123);
        repeat (3) @(negedge sys_clk);
        din = 8'd45; din_vld = 1'b1;
        @(negedge sys_clk);
        din_vld = 1'b0;
        drain();

        // Back-to-back with din_vld held high
        wait_idle();
        a = n_acc;
        din = 8'd9; din_vld = 1'b1;
        wait_acc(a + 1);
        din = 8'd10;
        wait_acc(a + 2);
        din_vld = 1'b0;
        drain();

        // Reset on the 4th SHIFT edge of a conversion
        send(8'd200);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (15) @(negedge sys_clk);

        // Exhaustive sweep
        for (int v = 0; v < 256; v++) send(8'(v));
        drain();

        // Random values, random gaps, random dropped pulses while busy
        for (int k = 0; k < 40; k++) begin
            send(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 6)) @(negedge sys_clk);
                din = 8'($urandom_range(0, 255)); din_vld = 1'b1;
                @(negedge sys_clk);
                din_vld = 1'b0;
            end
            repeat ($urandom_range(0, 3)) @(negedge sys_clk);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
